alu: RTL and testbench
======================

Name: alu

Overview:
- Registered 32-bit MIPS-subset execution unit.
- Decodes a raw instruction word and operates on two register-file operand values (gr1 = rs value, gr2 = rt value).
- Produces a 32-bit result, zero/overflow/negative flags, and HI/LO registers for multiply/divide.
- Sits in the EX stage between register read and writeback/memory address generation.

Parameters:
- None. Datapath width is fixed at 32.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- i_datain  in  32  instruction word: opcode [31:26], shamt [10:6], funct [5:0], imm [15:0]
- gr1  in  32  operand A (rs value)
- gr2  in  32  operand B (rt value)
- c  out  32  result
- zon  out  3  flags: [2] zero, [1] overflow, [0] negative
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Timing: all outputs are registered. Inputs are sampled on a clk rising edge; results are visible after that edge (latency 1). No handshake; a new instruction is accepted every cycle.
- Reset: rst high at a clk edge sets c, zon, hi and lo to 0 and overrides any operation in the same cycle.
- Operand B: gr2 for R-type. For I-type: sign-extended imm for addi, addiu, slti, sltiu, beq/bne-free ops, lw, sw; zero-extended imm for andi, ori, xori.
- R-type (opcode 0x00), by funct:
  - add 20, addu 21, sub 22, subu 23
  - and 24, or 25, xor 26, nor 27
  - slt 2A (signed compare), sltu 2B (unsigned compare)
  - sll 00, srl 02, sra 03: shift gr2 by shamt
  - sllv 04, srlv 06, srav 07: shift gr2 by gr1[4:0]
  - mult 18, multu 19, div 1A, divu 1B
- I-type, by opcode:
  - beq 04, bne 05: c = gr1 - gr2
  - addi 08, addiu 09
  - slti 0A (signed), sltiu 0B (unsigned compare against the sign-extended imm)
  - andi 0C, ori 0D, xori 0E
  - lw 23, sw 2B: c = gr1 + sext(imm)
- slt-family result: c = 32'd1 or 32'd0.
- Shifts: sra/srav are arithmetic (replicate bit 31); srl/srlv fill with zeros.
- Flags:
  - zero = (c == 0). For beq/bne this equals (gr1 == gr2).
  - negative = c[31].
  - overflow = signed two's-complement overflow, for add, addi, sub only; 0 for every other operation.
- mult/multu: {hi,lo} = full 64-bit product, signed or unsigned respectively.
- div/divu: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: hi and lo hold their previous values.
- For mult/multu/div/divu: c = 0 and zon = 000.
- hi and lo change only on mult/multu/div/divu (or reset); every other operation holds them.
- Unsupported opcode/funct: c = 0, zon = 000, hi/lo hold.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: mult, multu, div, divu behave as above.
- Undefined: those four funct codes are treated as unsupported. No multiplier or divider is synthesized, and hi/lo stay 0 after reset.

Test Plan:
- Reset: assert rst for 1 cycle with an arbitrary instruction -> c = 0, zon = 000, hi = 0, lo = 0.
- Add:
  - add gr1 = 0x40404040, gr2 = 0xDDDDDDDD -> c = 0x1E1E1E1D, zon = 000.
  - add gr1 = 0x7FFFFFFF, gr2 = 0x00000001 -> c = 0x80000000, zon = 011.
  - addu with the same operands -> zon = 001.
- Subtract/branch:
  - sub gr1 = gr2 = 0x5DDDDDDD -> c = 0, zon = 100.
  - beq with equal operands -> zon[2] = 1.
  - bne gr1 = 5, gr2 = 3 -> c = 2, zon = 000.
- Multiply/divide (macro defined):
  - mult gr1 = 0xFFFFFFFF, gr2 = 1 -> hi = lo = 0xFFFFFFFF.
  - div gr1 = 0xFFFFFFE1, gr2 = 0x11 -> lo = 0xFFFFFFFF, hi = 0xFFFFFFF2.
  - divu by 0 -> hi/lo unchanged.
- Shifts, gr2 = 0xDDDDDDDD:
  - sll shamt 1 -> 0xBBBBBBBA
  - srl shamt 1 -> 0x6EEEEEEE
  - sra shamt 1 -> 0xEEEEEEEE
  - sllv with gr1 = 2 -> 0x77777774
- Compare/logic:
  - slt gr1 = 0x40404040, gr2 = 0xDDDDDDDD -> c = 0; sltu with the same operands -> c = 1.
  - andi gr1 = 0xFFFFFFE1, imm 0x0011 -> c = 0x00000001.
  - lw gr1 = 0x40404040, imm 0x0020 -> c = 0x40404060.

Source files
------------

// File: rtl/alu.sv
// Registered 32-bit MIPS-subset EX-stage ALU: result, zero/overflow/negative flags, HI/LO.
// Define ALU_MULDIV_EN to build the mult/multu/div/divu datapath; otherwise those functs are unsupported.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_datain,
  input  logic [31:0] gr1,
  input  logic [31:0] gr2,
  output logic [31:0] c,
  output logic [2:0]  zon,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [4:0]   shamt;
  logic [15:0]  imm;
  logic         unused_c;

  assign opcode   = i_datain[31:26];
  assign funct    = i_datain[5:0];
  assign shamt    = i_datain[10:6];
  assign imm      = i_datain[15:0];
  // Register specifiers are resolved upstream; only the operand values arrive here.
  assign unused_c = ^i_datain[25:16];

  logic [W-1:0] opb_c;
  logic [W-1:0] sum_c;
  logic [W-1:0] diff_c;
  logic         add_ovf_c;
  logic         sub_ovf_c;
  logic         slt_c;
  logic         sltu_c;

  // Operand B: register for R-type and branches, zero-extended imm for logic immediates.
  always_comb begin
    opb_c = {{16{imm[15]}}, imm};
    if (opcode == OP_RTYPE || opcode == OP_BEQ || opcode == OP_BNE) begin
      opb_c = gr2;
    end else if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) begin
      opb_c = {16'h0000, imm};
    end
  end

  assign sum_c     = gr1 + opb_c;
  assign diff_c    = gr1 - opb_c;
  assign add_ovf_c = (gr1[W-1] == opb_c[W-1]) && (sum_c[W-1] != gr1[W-1]);
  assign sub_ovf_c = (gr1[W-1] != opb_c[W-1]) && (diff_c[W-1] != gr1[W-1]);
  assign slt_c     = $signed(gr1) < $signed(opb_c);
  assign sltu_c    = gr1 < opb_c;

`ifdef ALU_MULDIV_EN
  logic [2*W-1:0] prod_s_c;
  logic [2*W-1:0] prod_u_c;
  logic [W-1:0]   quot_s_c;
  logic [W-1:0]   rem_s_c;
  logic [W-1:0]   quot_u_c;
  logic [W-1:0]   rem_u_c;

  // Low 64 bits of a product of 64-bit sign/zero extensions equal the full 32x32 product.
  assign prod_s_c = {{W{gr1[W-1]}}, gr1} * {{W{gr2[W-1]}}, gr2};
  assign prod_u_c = {{W{1'b0}}, gr1} * {{W{1'b0}}, gr2};
  assign quot_s_c = $signed(gr1) / $signed(gr2);
  assign rem_s_c  = $signed(gr1) % $signed(gr2);
  assign quot_u_c = gr1 / gr2;
  assign rem_u_c  = gr1 % gr2;
`endif

  logic [W-1:0] res_c;
  logic         ovf_c;
  logic         valid_c;
  logic         hilo_we_c;
  logic [W-1:0] hi_nxt_c;
  logic [W-1:0] lo_nxt_c;

  // Operation decode; valid_c clear means unsupported or mult/div (both report zon = 000).
  always_comb begin
    res_c     = '0;
    ovf_c     = 1'b0;
    valid_c   = 1'b1;
    hilo_we_c = 1'b0;
    hi_nxt_c  = hi;
    lo_nxt_c  = lo;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   begin res_c = sum_c;  ovf_c = add_ovf_c; end
          F_ADDU:  res_c = sum_c;
          F_SUB:   begin res_c = diff_c; ovf_c = sub_ovf_c; end
          F_SUBU:  res_c = diff_c;
          F_AND:   res_c = gr1 & gr2;
          F_OR:    res_c = gr1 | gr2;
          F_XOR:   res_c = gr1 ^ gr2;
          F_NOR:   res_c = ~(gr1 | gr2);
          F_SLT:   res_c = {31'd0, slt_c};
          F_SLTU:  res_c = {31'd0, sltu_c};
          F_SLL:   res_c = gr2 << shamt;
          F_SRL:   res_c = gr2 >> shamt;
          F_SRA:   res_c = $signed(gr2) >>> shamt;
          F_SLLV:  res_c = gr2 << gr1[4:0];
          F_SRLV:  res_c = gr2 >> gr1[4:0];
          F_SRAV:  res_c = $signed(gr2) >>> gr1[4:0];
`ifdef ALU_MULDIV_EN
          F_MULT:  begin
            valid_c = 1'b0; hilo_we_c = 1'b1;
            {hi_nxt_c, lo_nxt_c} = prod_s_c;
          end
          F_MULTU: begin
            valid_c = 1'b0; hilo_we_c = 1'b1;
            {hi_nxt_c, lo_nxt_c} = prod_u_c;
          end
          F_DIV:   begin
            valid_c = 1'b0; hilo_we_c = (gr2 != '0);
            hi_nxt_c = rem_s_c; lo_nxt_c = quot_s_c;
          end
          F_DIVU:  begin
            valid_c = 1'b0; hilo_we_c = (gr2 != '0);
            hi_nxt_c = rem_u_c; lo_nxt_c = quot_u_c;
          end
`endif
          default: valid_c = 1'b0;
        endcase
      end
      OP_BEQ, OP_BNE:   res_c = diff_c;
      OP_ADDI:          begin res_c = sum_c; ovf_c = add_ovf_c; end
      OP_ADDIU:         res_c = sum_c;
      OP_SLTI:          res_c = {31'd0, slt_c};
      OP_SLTIU:         res_c = {31'd0, sltu_c};
      OP_ANDI:          res_c = gr1 & opb_c;
      OP_ORI:           res_c = gr1 | opb_c;
      OP_XORI:          res_c = gr1 ^ opb_c;
      OP_LW, OP_SW:     res_c = sum_c;
      default:          valid_c = 1'b0;
    endcase
  end

  // Output registers; reset wins over any operation in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      c   <= '0;
      zon <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      c   <= res_c;
      zon <= valid_c ? {(res_c == '0), ovf_c, res_c[W-1]} : 3'b000;
      if (hilo_we_c) begin
        hi <= hi_nxt_c;
        lo <= lo_nxt_c;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; mult/div expectations depend on ALU_MULDIV_EN.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] i_datain;
  logic [31:0] gr1;
  logic [31:0] gr2;
  logic [31:0] c;
  logic [2:0]  zon;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_total;
  int n_pass;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .i_datain (i_datain),
    .gr1      (gr1),
    .gr2      (gr2),
    .c        (c),
    .zon      (zon),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] sh);
    return {6'h00, 15'd0, sh, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  task automatic step(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    i_datain = instr;
    gr1      = a;
    gr2      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_cz(input string tag, input logic [31:0] exp_c, input logic [2:0] exp_z);
    chk({tag, ".c"}, c, exp_c);
    chk({tag, ".zon"}, {29'd0, zon}, {29'd0, exp_z});
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    i_datain = rtype(6'h20, 5'd0);
    gr1 = 32'h1234_5678;
    gr2 = 32'h0FED_CBA9;
    @(posedge clk);
    #1;
    chk_cz("reset", 32'h0, 3'b000);
    chk("reset.hi", hi, 32'h0);
    chk("reset.lo", lo, 32'h0);
    rst = 1'b0;

    step(rtype(6'h20, 5'd0), 32'h4040_4040, 32'hDDDD_DDDD); chk_cz("add", 32'h1E1E_1E1D, 3'b000);
    step(rtype(6'h20, 5'd0), 32'h7FFF_FFFF, 32'h0000_0001); chk_cz("add_ovf", 32'h8000_0000, 3'b011);
    step(rtype(6'h21, 5'd0), 32'h7FFF_FFFF, 32'h0000_0001); chk_cz("addu", 32'h8000_0000, 3'b001);
    step(rtype(6'h22, 5'd0), 32'h5DDD_DDDD, 32'h5DDD_DDDD); chk_cz("sub_zero", 32'h0, 3'b100);
    step(rtype(6'h22, 5'd0), 32'h8000_0000, 32'h0000_0001); chk_cz("sub_ovf", 32'h7FFF_FFFF, 3'b010);
    step(rtype(6'h23, 5'd0), 32'h8000_0000, 32'h0000_0001); chk_cz("subu", 32'h7FFF_FFFF, 3'b000);
    step(itype(6'h04, 16'h0010), 32'h1234_5678, 32'h1234_5678); chk_cz("beq_eq", 32'h0, 3'b100);
    step(itype(6'h05, 16'h0010), 32'h0000_0005, 32'h0000_0003); chk_cz("bne", 32'h2, 3'b000);

    step(rtype(6'h00, 5'd1), 32'h0, 32'hDDDD_DDDD); chk_cz("sll", 32'hBBBB_BBBA, 3'b001);
    step(rtype(6'h02, 5'd1), 32'h0, 32'hDDDD_DDDD); chk_cz("srl", 32'h6EEE_EEEE, 3'b000);
    step(rtype(6'h03, 5'd1), 32'h0, 32'hDDDD_DDDD); chk_cz("sra", 32'hEEEE_EEEE, 3'b001);
    step(rtype(6'h04, 5'd0), 32'h2, 32'hDDDD_DDDD); chk_cz("sllv", 32'h7777_7774, 3'b000);
    step(rtype(6'h07, 5'd0), 32'h24, 32'h8000_0000); chk_cz("srav", 32'hF800_0000, 3'b001);
    step(rtype(6'h06, 5'd0), 32'h24, 32'h8000_0000); chk_cz("srlv", 32'h0800_0000, 3'b000);

    step(rtype(6'h2A, 5'd0), 32'h4040_4040, 32'hDDDD_DDDD); chk_cz("slt", 32'h0, 3'b100);
    step(rtype(6'h2B, 5'd0), 32'h4040_4040, 32'hDDDD_DDDD); chk_cz("sltu", 32'h1, 3'b000);
    step(itype(6'h0A, 16'hFFFF), 32'h5, 32'h0); chk_cz("slti", 32'h0, 3'b100);
    step(itype(6'h0B, 16'hFFFF), 32'h5, 32'h0); chk_cz("sltiu", 32'h1, 3'b000);
    step(rtype(6'h27, 5'd0), 32'h0, 32'h0); chk_cz("nor", 32'hFFFF_FFFF, 3'b001);
    step(rtype(6'h26, 5'd0), 32'hF0F0_F0F0, 32'hFF00_FF00); chk_cz("xor", 32'h0FF0_0FF0, 3'b000);
    step(itype(6'h0C, 16'h0011), 32'hFFFF_FFE1, 32'h0); chk_cz("andi", 32'h1, 3'b000);
    step(itype(6'h0D, 16'h8000), 32'h0, 32'h0); chk_cz("ori_zext", 32'h0000_8000, 3'b000);
    step(itype(6'h0E, 16'hFFFF), 32'hFFFF_FFFF, 32'h0); chk_cz("xori", 32'hFFFF_0000, 3'b001);
    step(itype(6'h08, 16'h0001), 32'h7FFF_FFFF, 32'h0); chk_cz("addi_ovf", 32'h8000_0000, 3'b011);
    step(itype(6'h08, 16'hFFFF), 32'h5, 32'h0); chk_cz("addi_neg", 32'h4, 3'b000);
    step(itype(6'h09, 16'h0001), 32'h7FFF_FFFF, 32'h0); chk_cz("addiu", 32'h8000_0000, 3'b001);
    step(itype(6'h23, 16'h0020), 32'h4040_4040, 32'h0); chk_cz("lw", 32'h4040_4060, 3'b000);
    step(itype(6'h2B, 16'hFFFC), 32'h0000_1000, 32'h0); chk_cz("sw", 32'h0000_0FFC, 3'b000);
    step(rtype(6'h3F, 5'd0), 32'h1, 32'h2); chk_cz("bad_funct", 32'h0, 3'b000);
    step(itype(6'h3F, 16'h1234), 32'h1, 32'h2); chk_cz("bad_op", 32'h0, 3'b000);
    chk("hold.hi", hi, 32'h0);
    chk("hold.lo", lo, 32'h0);

`ifdef ALU_MULDIV_EN
    step(rtype(6'h18, 5'd0), 32'hFFFF_FFFF, 32'h1); chk_cz("mult", 32'h0, 3'b000);
    chk("mult.hi", hi, 32'hFFFF_FFFF);
    chk("mult.lo", lo, 32'hFFFF_FFFF);
    step(rtype(6'h19, 5'd0), 32'hFFFF_FFFF, 32'h2);
    chk("multu.hi", hi, 32'h0000_0001);
    chk("multu.lo", lo, 32'hFFFF_FFFE);
    step(rtype(6'h1A, 5'd0), 32'hFFFF_FFE1, 32'h11); chk_cz("div", 32'h0, 3'b000);
    chk("div.hi", hi, 32'hFFFF_FFF2);
    chk("div.lo", lo, 32'hFFFF_FFFF);
    step(rtype(6'h1B, 5'd0), 32'd100, 32'd7);
    chk("divu.hi", hi, 32'd2);
    chk("divu.lo", lo, 32'd14);
    step(rtype(6'h1B, 5'd0), 32'd55, 32'd0);
    chk("divu0.hi", hi, 32'd2);
    chk("divu0.lo", lo, 32'd14);
    step(rtype(6'h20, 5'd0), 32'd1, 32'd1); chk_cz("add_after", 32'd2, 3'b000);
    chk("add_after.hi", hi, 32'd2);
    chk("add_after.lo", lo, 32'd14);
`else
    step(rtype(6'h18, 5'd0), 32'hFFFF_FFFF, 32'h1); chk_cz("mult_off", 32'h0, 3'b000);
    chk("mult_off.hi", hi, 32'h0);
    chk("mult_off.lo", lo, 32'h0);
    step(rtype(6'h1A, 5'd0), 32'hFFFF_FFE1, 32'h11); chk_cz("div_off", 32'h0, 3'b000);
    chk("div_off.hi", hi, 32'h0);
    chk("div_off.lo", lo, 32'h0);
`endif

    rst = 1'b1;
    step(rtype(6'h20, 5'd0), 32'h7FFF_FFFF, 32'h1);
    chk_cz("reset_override", 32'h0, 3'b000);
    chk("reset_override.hi", hi, 32'h0);
    chk("reset_override.lo", lo, 32'h0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
